// File: rtl/onehot_index_player.sv
// Plays a queue of binary bit indices onto a one-hot output, holding each
// pattern for HOLD cycles; indices enter through a valid/ready FIFO.
module onehot_index_player #(
  parameter int IDX_W = 3,
  parameter int DEPTH = 4,
  parameter int HOLD  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IDX_W-1:0]          in_index,
  output logic [(2**IDX_W)-1:0]     out_onehot,
  output logic                      out_valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy
);

  localparam int OUT_W  = 2 ** IDX_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_next;
  logic [OUT_W-1:0]   onehot_next;
  logic               valid_next;
  logic               push;
  logic               pop;
  logic [IDX_W-1:0]   head;

  // Handshake: an index transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready looks only at the registered count, so
  // a full FIFO refuses a push even in a cycle that also pops.
  assign in_ready = !rst && (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rptr];
  assign busy     = out_valid || (count != '0);

  // State register plus the registered outputs and FIFO bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_onehot <= '0;
      out_valid  <= 1'b0;
      hold_cnt   <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
    end else begin
      state      <= state_next;
      out_onehot <= onehot_next;
      out_valid  <= valid_next;
      hold_cnt   <= hold_next;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_index;
  end

  // Next-state: a pop happens whenever a new pattern must be loaded.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (hold_cnt == '0) begin
          if (count != '0) pop = 1'b1;
          else             state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values to register; loading straight from SHOW leaves no gap cycle.
  always_comb begin
    onehot_next = out_onehot;
    valid_next  = out_valid;
    hold_next   = hold_cnt;
    if (pop) begin
      onehot_next = OUT_W'(1) << head;
      valid_next  = 1'b1;
      hold_next   = HOLD_W'(HOLD - 1);
    end else if (state == SHOW) begin
      if (hold_cnt != '0) begin
        hold_next = hold_cnt - HOLD_W'(1);
      end else begin
        onehot_next = '0;
        valid_next  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_index_player.sv
// Directed bench for onehot_index_player: a HOLD=4 instance and a HOLD=1
// instance, each checked against hand-computed tables.
module tb_onehot_index_player;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_index;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic [2:0] count;
  logic       busy;

  logic       in_valid1;
  logic       in_ready1;
  logic [2:0] in_index1;
  logic [7:0] out_onehot1;
  logic       out_valid1;
  logic [2:0] count1;
  logic       busy1;

  int vectors;
  int miscompares;

  onehot_index_player #(.IDX_W(3), .DEPTH(4), .HOLD(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_index(in_index), .out_onehot(out_onehot), .out_valid(out_valid),
    .count(count), .busy(busy)
  );

  onehot_index_player #(.IDX_W(3), .DEPTH(4), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_index(in_index1), .out_onehot(out_onehot1), .out_valid(out_valid1),
    .count(count1), .busy(busy1)
  );

  // Clock: rising edges at 5, 15, 25 ...; inputs and checks on falling edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] b2b_idx [3];
    logic [7:0] b2b_oh  [14];
    logic [2:0] b2b_cnt [14];
    logic [7:0] fill_oh [15];
    logic [2:0] fill_cnt[15];
    logic       fill_rdy[15];
    logic [2:0] rs_idx  [3];
    logic [2:0] h1_idx  [3];
    logic [7:0] h1_oh   [5];
    logic [2:0] h1_cnt  [5];
    int         next_idx;
    logic       acc;

    b2b_idx  = '{3'd0, 3'd7, 3'd3};
    b2b_oh   = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80,
                 8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
    b2b_cnt  = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1,
                 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    fill_oh  = '{8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04, 8'h04, 8'h04,
                 8'h08, 8'h08, 8'h08, 8'h08, 8'h10, 8'h10};
    fill_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4, 3'd4,
                 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd4};
    fill_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rs_idx   = '{3'd2, 3'd6, 3'd7};
    h1_idx   = '{3'd1, 3'd2, 3'd4};
    h1_oh    = '{8'h00, 8'h02, 8'h04, 8'h10, 8'h00};
    h1_cnt   = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0};

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_index    = '0;
    in_valid1   = 1'b0;
    in_index1   = '0;

    // Reset is asynchronous: values must hold before any clock edge.
    #1;
    chk("rst_onehot", out_onehot, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_in_ready1", in_ready1, 1'b1);

    // Single entry: push 5 at edge k.
    in_valid = 1'b1;
    in_index = 3'd5;
    tick();
    in_valid = 1'b0;
    chk("single_k_count", count, 3'd1);
    chk("single_k_valid", out_valid, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("single_oh_k%0d", i), out_onehot, 8'h20);
      chk($sformatf("single_valid_k%0d", i), out_valid, 1'b1);
      chk($sformatf("single_count_k%0d", i), count, 3'd0);
    end
    tick();
    chk("single_end_oh", out_onehot, 8'h00);
    chk("single_end_valid", out_valid, 1'b0);
    chk("single_end_busy", busy, 1'b0);

    // Back-to-back: 0, 7, 3 on consecutive edges, no gap between patterns.
    for (int t = 0; t < 14; t++) begin
      in_valid = (t < 3);
      in_index = (t < 3) ? b2b_idx[t] : 3'd0;
      tick();
      chk($sformatf("b2b_oh_t%0d", t), out_onehot, b2b_oh[t]);
      chk($sformatf("b2b_valid_t%0d", t), out_valid, b2b_oh[t] != 8'h00);
      chk($sformatf("b2b_count_t%0d", t), count, b2b_cnt[t]);
    end
    in_valid = 1'b0;

    // Fill / backpressure: offer indices 1..8 continuously.
    next_idx = 1;
    for (int t = 0; t < 15; t++) begin
      acc      = in_ready && (next_idx <= 8);
      in_valid = (next_idx <= 8);
      in_index = 3'(next_idx);
      tick();
      if (acc) next_idx++;
      chk($sformatf("fill_oh_t%0d", t), out_onehot, fill_oh[t]);
      chk($sformatf("fill_count_t%0d", t), count, fill_cnt[t]);
      chk($sformatf("fill_ready_t%0d", t), in_ready, fill_rdy[t]);
    end
    in_valid = 1'b0;
    chk("fill_all_accepted", next_idx, 9);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("fill_drain_busy", busy, 1'b0);

    // Async reset mid-SHOW while 8'h04 is held with two entries queued.
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      in_index = rs_idx[t];
      tick();
    end
    in_valid = 1'b0;
    chk("rs_pre_oh", out_onehot, 8'h04);
    chk("rs_pre_count", count, 3'd2);
    #2 rst = 1'b1;
    #1;
    chk("rs_oh", out_onehot, 8'h00);
    chk("rs_valid", out_valid, 1'b0);
    chk("rs_count", count, 3'd0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_in_ready", in_ready, 1'b0);
    #1 rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk($sformatf("rs_after_oh_t%0d", t), out_onehot, 8'h00);
      chk($sformatf("rs_after_count_t%0d", t), count, 3'd0);
    end

    // HOLD=1 instance: one pattern per cycle.
    for (int t = 0; t < 5; t++) begin
      in_valid1 = (t < 3);
      in_index1 = (t < 3) ? h1_idx[t] : 3'd0;
      tick();
      chk($sformatf("h1_oh_t%0d", t), out_onehot1, h1_oh[t]);
      chk($sformatf("h1_valid_t%0d", t), out_valid1, h1_oh[t] != 8'h00);
      chk($sformatf("h1_count_t%0d", t), count1, h1_cnt[t]);
    end
    in_valid1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
